// File: rtl/kernel_ram_loader_pkg.sv
// Shared types and constants for the kernel RAM loader.
package kernel_ram_loader_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 2;

   typedef logic [31:0] sum_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WRITE,
      ST_VERIFY,
      ST_DONE
   } state_t;

   // Expands a byteenable into a 32-bit data mask.
   function automatic sum_t be_mask(input logic [LANES-1:0] be);
      sum_t m;
      m = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/kernel_ram_loader_pack.sv
// Little-endian byte-lane packer: merges one byte into the word being assembled.
module kernel_ram_loader_pack
   import kernel_ram_loader_pkg::*;
(
   input  logic [LANE_W-1:0] lane_i,
   input  logic [31:0]       word_i,
   input  logic [LANES-1:0]  be_i,
   input  logic [7:0]        byte_i,
   input  logic              last_i,
   output logic [LANE_W-1:0] lane_o,
   output logic [31:0]       word_o,
   output logic [LANES-1:0]  be_o,
   output logic              full_o
);

   always_comb begin
      word_o = word_i;
      be_o   = be_i;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (lane_i == i[LANE_W-1:0]) begin
            word_o[8*i +: 8] = byte_i;
            be_o[i]          = 1'b1;
         end
      end
      lane_o = lane_i + LANE_W'(1);
      full_o = (lane_i == LANE_W'(LANES - 1)) || last_i;
   end

endmodule

// File: rtl/kernel_ram_loader.sv
// Streams bytes into on-chip RAM as 32-bit words; optional read-back check
// compiled in with KERNEL_RAM_LOADER_VERIFY_EN.
module kernel_ram_loader
   import kernel_ram_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned CNT_W  = 13
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  byte_count,
   output logic              busy,
   output logic              done,
   output logic              error,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [31:0]       ram_writedata,
   output logic              ram_clken,
   input  logic [31:0]       ram_readdata
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    remain_q, remain_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [LANES-1:0]    be_q, be_d;
   logic                error_q, error_d;
   sum_t                sum_q, sum_d;

   logic [LANE_W-1:0]   pk_lane;
   logic [31:0]         pk_word;
   logic [LANES-1:0]    pk_be;
   logic                pk_full;

`ifdef KERNEL_RAM_LOADER_VERIFY_EN
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    wcnt_q, wcnt_d;
   logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
   logic [LANES-1:0]    last_be_q, last_be_d;
   logic [LANES-1:0]    pend_be_q, pend_be_d;
   logic                rd_pend_q, rd_pend_d;
   sum_t                rsum_q, rsum_d;
   sum_t                rsum_acc;
`else
   logic                unused_rd;
   assign unused_rd = ^ram_readdata;
`endif

   kernel_ram_loader_pack u_pack (
      .lane_i (lane_q),
      .word_i (wdata_q),
      .be_i   (be_q),
      .byte_i (s_data),
      .last_i (remain_q == CNT_W'(1)),
      .lane_o (pk_lane),
      .word_o (pk_word),
      .be_o   (pk_be),
      .full_o (pk_full)
   );

   assign ram_clken = reset_n;
   assign error     = error_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      lane_d   = lane_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      error_d  = error_q;
      sum_d    = sum_q;
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
      base_d    = base_q;
      wcnt_d    = wcnt_q;
      rd_idx_d  = rd_idx_q;
      last_be_d = last_be_q;
      pend_be_d = pend_be_q;
      rd_pend_d = rd_pend_q;
      rsum_d    = rsum_q;
      rsum_acc  = rsum_q;
`endif
      busy           = (state_q != ST_IDLE);
      done           = (state_q == ST_DONE);
      s_ready        = (state_q == ST_FILL);
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      ram_address    = addr_q;
      ram_writedata  = '0;
      ram_byteenable = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               error_d  = 1'b0;
               sum_d    = '0;
               addr_d   = start_addr;
               remain_d = byte_count;
               lane_d   = '0;
               wdata_d  = '0;
               be_d     = '0;
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
               base_d    = start_addr;
               wcnt_d    = '0;
               rd_idx_d  = '0;
               rd_pend_d = 1'b0;
               rsum_d    = '0;
`endif
               state_d  = (byte_count == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (s_valid) begin
               wdata_d  = pk_word;
               be_d     = pk_be;
               lane_d   = pk_lane;
               remain_d = remain_q - CNT_W'(1);
               if (pk_full) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_writedata  = wdata_q;
            ram_byteenable = be_q;
            sum_d   = sum_q + wdata_q;
            addr_d  = addr_q + ADDR_W'(1);
            if (addr_q == '1) error_d = 1'b1;
            wdata_d = '0;
            be_d    = '0;
            lane_d  = '0;
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
            wcnt_d    = wcnt_q + CNT_W'(1);
            last_be_d = be_q;
            state_d   = (remain_q == '0) ? ST_VERIFY : ST_FILL;
`else
            state_d   = (remain_q == '0) ? ST_DONE : ST_FILL;
`endif
         end
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
         // Reads are pipelined: issue word i while accumulating word i-1;
         // the extra cycle after the last issue folds in the final word.
         ST_VERIFY: begin
            if (rd_pend_q) rsum_acc = rsum_q + (ram_readdata & be_mask(pend_be_q));
            rsum_d    = rsum_acc;
            rd_pend_d = 1'b0;
            if (rd_idx_q != wcnt_q) begin
               ram_chipselect = 1'b1;
               ram_address    = base_q + ADDR_W'(rd_idx_q);
               rd_pend_d      = 1'b1;
               pend_be_d      = (rd_idx_q == wcnt_q - CNT_W'(1)) ? last_be_q : '1;
               rd_idx_d       = rd_idx_q + CNT_W'(1);
            end else begin
               if (rsum_acc != sum_q) error_d = 1'b1;
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         lane_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         error_q  <= 1'b0;
         sum_q    <= '0;
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
         base_q    <= '0;
         wcnt_q    <= '0;
         rd_idx_q  <= '0;
         last_be_q <= '0;
         pend_be_q <= '0;
         rd_pend_q <= 1'b0;
         rsum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         lane_q   <= lane_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         error_q  <= error_d;
         sum_q    <= sum_d;
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
         base_q    <= base_d;
         wcnt_q    <= wcnt_d;
         rd_idx_q  <= rd_idx_d;
         last_be_q <= last_be_d;
         pend_be_q <= pend_be_d;
         rd_pend_q <= rd_pend_d;
         rsum_q    <= rsum_d;
`endif
      end
   end

endmodule

// File: tb/tb_kernel_ram_loader.sv
// Scoreboard bench for kernel_ram_loader; the RAM model can corrupt word 0x011.
module tb_kernel_ram_loader;

   localparam int ADDR_W = 11;
   localparam int CNT_W  = 13;
`ifdef KERNEL_RAM_LOADER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [CNT_W-1:0]  byte_count;
   logic              busy, done, error;
   logic [7:0]        s_data;
   logic              s_valid, s_ready;
   logic [ADDR_W-1:0] ram_address;
   logic [3:0]        ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken;
   logic [31:0]       ram_writedata, ram_readdata;

   kernel_ram_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .start_addr     (start_addr),
      .byte_count     (byte_count),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [3:0]        be;
      logic [31:0]       d;
   } wr_t;
   typedef struct {
      logic err;
      int   lat;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  last_wr = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // RAM model: byte-enabled writes, one-cycle read latency, optional corruption
   logic [31:0] mem [0:2047];
   logic        corrupt = 1'b0;
   always @(posedge clk) begin
      if (ram_chipselect && ram_write) begin
         for (int i = 0; i < 4; i++)
            if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
      end
      if (ram_chipselect && !ram_write)
         ram_readdata <= mem[ram_address] ^ ((corrupt && ram_address == 11'h011) ? 32'h1 : 32'h0);
   end

   // Monitor
   always @(negedge clk) begin
      wr_t w;
      dn_t e;
      cyc++;
      if (reset_n && ram_chipselect && ram_write) begin
         last_wr = cyc;
         chk("write_pending", 64'(wq.size() > 0), 64'd1);
         if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("wr_addr", 64'(ram_address), 64'(w.a));
            chk("wr_be", 64'(ram_byteenable), 64'(w.be));
            chk("wr_data", 64'(ram_writedata), 64'(w.d));
         end
      end
      if (done) begin
         chk("done_pending", 64'(dq.size() > 0), 64'd1);
         if (dq.size() > 0) begin
            e = dq.pop_front();
            chk("done_err", 64'(error), 64'(e.err));
            if (e.lat > 0) chk("done_lat", 64'(cyc - last_wr), 64'(e.lat));
         end
      end
   end

   function automatic int lat(input int nwords);
      return VERIFY ? nwords + 2 : 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
      start      = 1'b1;
      start_addr = a;
      byte_count = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      s_data  = b;
      s_valid = 1'b1;
      for (int k = 0; k < 50 && !s_ready; k++) tick();
      chk("s_ready_wait", 64'(s_ready), 64'd1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) send(first + 8'(i));
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && busy; k++) tick();
      chk("idle_wait", 64'(busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, 64'({busy, done, error, s_ready, ram_chipselect, ram_write, ram_clken,
                   ram_address, ram_byteenable, ram_writedata}), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; start_addr = '0; byte_count = '0;
      s_data = '0; s_valid = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset_outputs");
      reset_n = 1'b1;
      #1;
      chk("clken_after_reset", 64'(ram_clken), 64'd1);
      tick();

      // 8 bytes from 0x010
      wq.push_back('{11'h010, 4'hF, 32'h04030201});
      wq.push_back('{11'h011, 4'hF, 32'h08070605});
      dq.push_back('{1'b0, lat(2)});
      do_start(11'h010, 13'd8);
      send_seq(8'h01, 8);
      wait_idle();

      // 6 bytes: partial final word
      wq.push_back('{11'h030, 4'hF, 32'h04030201});
      wq.push_back('{11'h031, 4'h3, 32'h00000605});
      dq.push_back('{1'b0, lat(2)});
      do_start(11'h030, 13'd6);
      send_seq(8'h01, 6);
      wait_idle();

      // address wrap sets error
      wq.push_back('{11'h7FF, 4'hF, 32'h04030201});
      wq.push_back('{11'h000, 4'hF, 32'h08070605});
      dq.push_back('{1'b1, lat(2)});
      do_start(11'h7FF, 13'd8);
      send_seq(8'h01, 8);
      wait_idle();
      chk("error_sticky", 64'(error), 64'd1);

      // zero-length command
      dq.push_back('{1'b0, 0});
      do_start(11'h0AA, 13'd0);
      chk("zero_done_next", 64'(done), 64'd1);
      chk("zero_no_cs", 64'(ram_chipselect), 64'd0);
      tick();
      chk("zero_done_once", 64'({done, busy}), 64'd0);

      // start while busy is ignored
      wq.push_back('{11'h040, 4'hF, 32'h0D0C0B0A});
      dq.push_back('{1'b0, lat(1)});
      do_start(11'h040, 13'd4);
      send(8'h0A);
      start = 1'b1; start_addr = 11'h100; byte_count = 13'd2;
      tick();
      start = 1'b0;
      send_seq(8'h0B, 3);
      wait_idle();

      // reset mid-command, then a normal command
      do_start(11'h050, 13'd8);
      send_seq(8'h01, 3);
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset_outputs");
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      wq.push_back('{11'h060, 4'hF, 32'h24232221});
      wq.push_back('{11'h061, 4'hF, 32'h28272625});
      dq.push_back('{1'b0, lat(2)});
      do_start(11'h060, 13'd8);
      send_seq(8'h21, 8);
      wait_idle();

      if (VERIFY) begin
         corrupt = 1'b1;
         wq.push_back('{11'h010, 4'hF, 32'h04030201});
         wq.push_back('{11'h011, 4'hF, 32'h08070605});
         dq.push_back('{1'b1, lat(2)});
         do_start(11'h010, 13'd8);
         send_seq(8'h01, 8);
         wait_idle();
         corrupt = 1'b0;
         wq.push_back('{11'h010, 4'hF, 32'h04030201});
         wq.push_back('{11'h011, 4'hF, 32'h08070605});
         dq.push_back('{1'b0, lat(2)});
         do_start(11'h010, 13'd8);
         send_seq(8'h01, 8);
         wait_idle();
      end

      for (int k = 0; k < 100 && (wq.size() + dq.size()) != 0; k++) tick();
      chk("queues_drained", 64'(wq.size() + dq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/kernel_ram_loader.md
KERNEL_RAM_LOADER -- requirements
Module: kernel_ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM word-address width (2048 x 32-bit words).
REQ-002 SHALL have parameter CNT_W, default 13, byte_count width (max 8191 bytes).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports start in 1 (command pulse), start_addr in ADDR_W (first word address), byte_count in CNT_W (bytes to load).
REQ-006 SHALL have ports busy out 1 (command active), done out 1 (one-cycle completion pulse), error out 1 (sticky until next accepted start).
REQ-007 SHALL have ports s_data in 8, s_valid in 1, s_ready out 1 (byte-stream sink, little-endian).
REQ-008 SHALL have ports ram_address out ADDR_W, ram_byteenable out 4, ram_chipselect out 1, ram_write out 1, ram_writedata out 32, ram_clken out 1, ram_readdata in 32 (Avalon master into single-port on-chip RAM).

Function
REQ-009 SHALL implement states IDLE, FILL, WRITE, VERIFY, DONE.
REQ-010 SHALL accept start only in IDLE; start while busy ignored; busy=1 in every state except IDLE.
REQ-011 SHALL, on start with byte_count=0, go directly to DONE: no RAM access, done pulses on the following cycle.
REQ-012 SHALL, on start with byte_count>0, latch start_addr/byte_count, clear error, enter FILL.
REQ-013 SHALL drive s_ready=1 only in FILL; a byte transfers when s_valid&s_ready.
REQ-014 SHALL place byte k at lane k mod 4 (writedata[8*lane+7:8*lane]) and set that byteenable bit.
REQ-015 SHALL enter WRITE after the lane-3 byte or the final byte, whichever first; WRITE lasts exactly one cycle with chipselect=write=1, then returns to FILL or advances at end of command.
REQ-016 SHALL zero unused writedata lanes; byteenable on a partial final word covers only filled lanes (e.g. 4'b0011).
REQ-017 SHALL increment ram_address by 1 after each WRITE, wrapping 2^ADDR_W-1 -> 0 and setting error on wrap.
REQ-018 SHALL drive ram_chipselect=ram_write=0 outside WRITE/VERIFY; ram_clken SHALL be 1 whenever reset_n=1.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL keep a 32-bit mod-2^32 running sum of written words (unenabled lanes zero).

Reset
REQ-021 SHALL, while reset_n=0, force state IDLE, busy=done=error=s_ready=0, ram_chipselect=ram_write=ram_clken=0, ram_address=ram_byteenable=ram_writedata=0, sum=0.
REQ-022 SHALL, on reset mid-command, abandon the command with no done pulse; partial RAM contents are undefined.

Configuration
REQ-023 SHALL use macro KERNEL_RAM_LOADER_VERIFY_EN to compile the read-back check in or out.
REQ-024 SHALL, with the macro defined, enter VERIFY after the final WRITE: reread each written word from start_addr (chipselect=1, write=0), readdata valid one cycle after address, masked by that word's byteenable, summed; mismatch vs write sum sets error before done.
REQ-025 SHALL, without the macro, skip VERIFY (final WRITE -> DONE), ignore ram_readdata, and omit the read-sum logic.

Structure
REQ-026 SHALL place the state enum, the 32-bit sum type, and lane-count constant (4) in package kernel_ram_loader_pkg.
REQ-027 SHALL factor byte-lane packing (lane index, writedata, byteenable, word-complete flag) into sub-module kernel_ram_loader_pack.

Verification
REQ-028 SHALL cover: start_addr=0x010, byte_count=8, bytes 01..08 -> writes 0x04030201@0x010 and 0x08070605@0x011, byteenable 4'hF, done 1 cycle after last WRITE (no verify), error=0.
REQ-029 SHALL cover: byte_count=6 -> second write byteenable 4'b0011, writedata 0x00000605.
REQ-030 SHALL cover: start_addr=0x7FF, byte_count=8 -> writes @0x7FF then @0x000, error=1 at done.
REQ-031 SHALL cover: byte_count=0 -> no chipselect, done pulses next cycle; start asserted while busy -> ignored.
REQ-032 SHALL cover: VERIFY_EN, bench RAM model corrupts word @0x011 -> error=1 at done; clean model -> error=0.
REQ-033 SHALL cover: reset_n low after 3 of 8 bytes -> all outputs 0 immediately, no done; subsequent start completes normally.
